// File: rtl/pad_cfg_serial_loader.sv
// Per-pad configuration image that is shifted into the daisy-chained pad control blocks and then latched.
// Optional chain readback check is enabled by defining PAD_CFG_READBACK_EN.
module pad_cfg_serial_loader #(
  parameter int unsigned NUM_PADS = 38,
  parameter int unsigned CFG_WIDTH = 13,
  parameter int unsigned CLK_DIV = 4,
  parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG = 13'h0403,
  localparam int unsigned IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [CFG_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [CFG_WIDTH-1:0] rd_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 serial_clock,
  output logic                 serial_data,
  output logic                 serial_load,
  input  logic                 serial_data_in,
  output logic                 rb_mismatch
);

  localparam int unsigned NBITS = NUM_PADS * CFG_WIDTH;
  localparam int unsigned CNT_W = $clog2(NBITS + 1);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [CFG_WIDTH-1:0] image [NUM_PADS];
  logic [NBITS-1:0]     img_flat;
  logic                 wr_ok;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             sload_q, sload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sample_c;
  logic             start_ok;

  assign wr_ok    = (state_q == S_IDLE) && wr_en && (32'(wr_idx) < NUM_PADS);
  assign start_ok = (state_q == S_IDLE) && start;

  // Configuration image; only writable while the loader is idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) image[p] <= DEFAULT_CFG;
    end else if (wr_ok) begin
      image[wr_idx] <= wr_data;
    end
  end

  assign rd_data = (32'(rd_idx) < NUM_PADS) ? image[rd_idx] : '0;

  // Flattened image with a same-cycle write folded in; pad NUM_PADS-1 occupies the MSBs
  always_comb begin
    img_flat = '0;
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      img_flat[p*CFG_WIDTH +: CFG_WIDTH] = (wr_ok && (32'(wr_idx) == p)) ? wr_data : image[p];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sload_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sload_q <= sload_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sclk_d   = sclk_q;
    sdata_d  = sdata_q;
    sload_d  = sload_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sample_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = S_SHIFT;
          shift_d = img_flat;
          sdata_d = img_flat[NBITS-1];
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d   = 1'b1;
            sample_c = 1'b1;
          end else begin
            // End of a bit's high half: advance to the next bit or hand off to the load strobe
            sclk_d = 1'b0;
            if (bit_q == CNT_W'(NBITS - 1)) begin
              state_d = S_LOAD;
              sload_d = 1'b1;
              sdata_d = 1'b0;
            end else begin
              bit_d   = bit_q + CNT_W'(1);
              shift_d = shift_q << 1;
              sdata_d = shift_d[NBITS-1];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LOAD: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          sload_d = 1'b0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;

`ifdef PAD_CFG_READBACK_EN
  logic [NBITS-1:0] shadow_q;
  logic [NBITS-1:0] sent_q;
  logic [NBITS-1:0] prev_q;
  logic             rb_q;

  // Chain return shadow compared against what the previous transfer left in the chain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      sent_q   <= '0;
      prev_q   <= {NUM_PADS{DEFAULT_CFG}};
      rb_q     <= 1'b0;
    end else begin
      if (start_ok) begin
        sent_q <= img_flat;
        rb_q   <= 1'b0;
      end
      if (sample_c) shadow_q <= (shadow_q << 1) | NBITS'(serial_data_in);
      if (done_d) begin
        if (shadow_q != prev_q) rb_q <= 1'b1;
        prev_q <= sent_q;
      end
    end
  end

  assign rb_mismatch = rb_q;
`else
  logic unused_rb;
  assign unused_rb   = serial_data_in ^ sample_c ^ start_ok;
  assign rb_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pad_cfg_serial_loader.sv
// Directed bench for pad_cfg_serial_loader with a 4-pad x 4-bit image and a looped 16-bit chain model.
module tb_pad_cfg_serial_loader;

  localparam int unsigned NP = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned CD = 2;
  localparam logic [3:0]  DEF = 4'h3;
  localparam int unsigned BUSY_LEN = 2 * CD * NP * CW + CD + 1;
`ifdef PAD_CFG_READBACK_EN
  localparam logic RB_EXP = 1'b1;
`else
  localparam logic RB_EXP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [3:0] wr_data = '0;
  logic [1:0] rd_idx = '0;
  logic [3:0] rd_data;
  logic       start = 1'b0;
  logic       busy, done, serial_clock, serial_data, serial_load;
  logic       serial_data_in;
  logic       rb_mismatch;

  pad_cfg_serial_loader #(
    .NUM_PADS(NP), .CFG_WIDTH(CW), .CLK_DIV(CD), .DEFAULT_CFG(DEF)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .rd_data(rd_data), .start(start), .busy(busy), .done(done),
    .serial_clock(serial_clock), .serial_data(serial_data), .serial_load(serial_load),
    .serial_data_in(serial_data_in), .rb_mismatch(rb_mismatch)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Passive monitors
  int busy_cnt = 0, done_cnt = 0, load_cnt = 0, rise_cnt = 0, load_rise = 0, load_data_bad = 0;
  logic [15:0] cap = '0;

  always @(posedge clock) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (serial_load) begin
      load_cnt++;
      load_rise = rise_cnt;
      if (serial_data) load_data_bad++;
    end
  end

  always @(posedge serial_clock) begin
    cap = {cap[14:0], serial_data};
    rise_cnt++;
  end

  // Chain model: 16-bit shift register whose far end feeds back to serial_data_in
  logic [15:0] chain;
  logic        corrupt = 1'b0;
  always @(posedge serial_clock or posedge reset or posedge corrupt) begin
    if (reset)        chain <= {NP{DEF}};
    else if (corrupt) chain <= chain ^ 16'h0001;
    else              chain <= {chain[14:0], serial_data};
  end
  assign serial_data_in = chain[15];

  int b0, d0, l0, r0;
  logic rb_at_done, busy_at_done;

  task automatic snap();
    b0 = busy_cnt; d0 = done_cnt; l0 = load_cnt; r0 = rise_cnt;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic write_pad(input logic [1:0] idx, input logic [3:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    rb_at_done   = rb_mismatch;
    busy_at_done = busy;
    tick();
  endtask

  task automatic check_image(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("%s_pad%0d", tag, i), 32'(rd_data), 32'(exp[i*4 +: 4]));
    end
  endtask

  task automatic check_transfer(input string tag, input logic [15:0] exp_bits);
    check({tag, "_bits"}, 32'(cap), 32'(exp_bits));
    check({tag, "_rises"}, 32'(rise_cnt - r0), 32'd16);
    check({tag, "_busy_len"}, 32'(busy_cnt - b0), BUSY_LEN);
    check({tag, "_load_len"}, 32'(load_cnt - l0), 32'(CD));
    check({tag, "_load_after"}, 32'(load_rise - r0), 32'd16);
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_outs", 32'({busy, done, serial_clock, serial_data, serial_load, rb_mismatch}), 32'd0);
    reset = 1'b0;
    tick();
    check_image("rst_img", 16'h3333);
    check("idle_outs", 32'({busy, done, serial_clock, serial_data, serial_load, rb_mismatch}), 32'd0);

    // Basic write and transfer
    write_pad(2'd0, 4'h1);
    write_pad(2'd1, 4'h2);
    write_pad(2'd2, 4'h4);
    write_pad(2'd3, 4'h8);
    check_image("wr_img", 16'h8421);
    snap();
    pulse_start();
    check("busy_start", 32'(busy), 32'd1);
    wait_done();
    check_transfer("xfer1", 16'h8421);
    check("xfer1_rb", 32'(rb_at_done), 32'd0);

    // Write and start while busy are ignored
    snap();
    pulse_start();
    repeat (10) tick();
    wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'hF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_done();
    repeat (20) tick();
    check_transfer("ign", 16'h8421);
    check_image("ign_img", 16'h8421);

    // Reset in the middle of the 9th bit
    snap();
    pulse_start();
    repeat (33) @(posedge clock);
    #2;
    check("mid_rises", 32'(rise_cnt - r0), 32'd8);
    check("mid_sclk", 32'(serial_clock), 32'd0);
    reset = 1'b1;
    #1;
    check("arst_outs", 32'({busy, done, serial_clock, serial_data, serial_load, rb_mismatch}), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("arst_no_load", 32'(load_cnt - l0), 32'd0);
    check_image("arst_img", 16'h3333);
    snap();
    pulse_start();
    wait_done();
    check_transfer("post_rst", 16'h3333);

    // Same-cycle write and start
    snap();
    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 4'hA; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_done();
    check("same_first4", 32'(cap[15:12]), 32'hA);
    check_transfer("same", 16'hA333);
    check_image("same_img", 16'hA333);

    // Chain readback
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    snap();
    pulse_start();
    wait_done();
    check_transfer("rb1", 16'h3333);
    check("rb1_flag", 32'(rb_at_done), 32'd0);
    corrupt = 1'b1;
    #1;
    corrupt = 1'b0;
    tick();
    snap();
    pulse_start();
    wait_done();
    check("rb2_flag", 32'(rb_at_done), 32'(RB_EXP));
    check("rb2_sticky", 32'(rb_mismatch), 32'(RB_EXP));
    pulse_start();
    check("rb3_clear", 32'(rb_mismatch), 32'd0);
    wait_done();
    check("rb3_flag", 32'(rb_at_done), 32'd0);
    check("load_data_zero", 32'(load_data_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pad_cfg_serial_loader.md
Name: pad_cfg_serial_loader

Overview:
- Parametrised successor to the fixed user-pad wiring in the padframe.
- Holds a per-pad configuration image for NUM_PADS user pads and shifts it, on command, into the daisy-chained pad control blocks. Each pad control block carries the oeb, inp_dis, dm[2:0], vtrip_sel, slow_sel, analog_* and holdover fields.
- Generates a divided serial clock, then a load strobe, then reports completion.
- Sits between the management core register bank and the padframe.

Parameters:
- NUM_PADS, 38, number of pads in the chain (1..64)
- CFG_WIDTH, 13, configuration bits per pad (1..16)
- CLK_DIV, 4, half-period of serial_clock in clock cycles (>=1)
- DEFAULT_CFG, 13'h0403, reset value of every pad's configuration word

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- wr_en  input  1  write one pad's configuration word
- wr_idx  input  $clog2(NUM_PADS)  pad index for the write
- wr_data  input  CFG_WIDTH  configuration word to write
- rd_idx  input  $clog2(NUM_PADS)  pad index for readback
- rd_data  output  CFG_WIDTH  image word at rd_idx (combinational)
- start  input  1  pulse: begin shift-and-load
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at completion
- serial_clock  output  1  chain shift clock
- serial_data  output  1  chain data, changes while serial_clock is low
- serial_load  output  1  chain load strobe
- serial_data_in  input  1  chain return data (used only with the optional feature)
- rb_mismatch  output  1  sticky readback mismatch flag (optional feature)

Behaviour:
- Reset:
  - All image words are set to DEFAULT_CFG.
  - FSM goes to IDLE.
  - busy, done, serial_clock, serial_data, serial_load and rb_mismatch are 0.
  - Reset takes effect immediately, including mid-transfer. The chain is then left unloaded and serial_load is never asserted.
- NBITS = NUM_PADS*CFG_WIDTH. The bit counter is $clog2(NBITS+1) wide. The divider counter is $clog2(CLK_DIV) wide (minimum 1).
- Writes:
  - Accepted only in IDLE; image[wr_idx] <= wr_data on the next edge.
  - Writes while busy are ignored.
  - wr_idx >= NUM_PADS is ignored.
- FSM states:
  - IDLE: start=1 moves to SHIFT next cycle; busy=1 from that cycle.
  - SHIFT:
    - Bit order is pad NUM_PADS-1 first, MSB first within each word; the last bit sent is pad 0 bit 0.
    - Each bit presents serial_data with serial_clock=0 for CLK_DIV cycles, then serial_clock=1 for CLK_DIV cycles.
    - After NBITS bits, go to LOAD with serial_clock=0.
  - LOAD: serial_load=1 for CLK_DIV cycles; serial_data=0. Then go to DONE.
  - DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- Total busy duration is 2*CLK_DIV*NBITS + CLK_DIV + 1 cycles.
- start while busy is ignored.
- start and wr_en in the same IDLE cycle: the write lands first, and the transfer shifts the updated image.
- The image is snapshotted into the shift register at SHIFT entry. Later writes cannot occur (busy blocks them), so the transferred data is exactly the image at start.

Optional Feature:
- Macro: PAD_CFG_READBACK_EN.
- When defined:
  - serial_data_in is sampled on each serial_clock rising edge during SHIFT into a return shadow of NBITS bits. This shadow holds the chain's previous contents.
  - In DONE, the shadow is compared with the image shifted by the previous completed transfer (DEFAULT_CFG for every pad after reset).
  - On mismatch, rb_mismatch is set and stays high until reset or the next start.
- When undefined: serial_data_in is unused, rb_mismatch is tied to 0, and no shadow registers exist.

Test Plan:
- Reset, then read all indices, with NUM_PADS=4, CFG_WIDTH=4, CLK_DIV=2, DEFAULT_CFG=4'h3 -> every rd_data=4'h3; all outputs 0.
- Write pads 0..3 with 4'h1, 4'h2, 4'h4, 4'h8, then start -> serial_data sampled at serial_clock rising edges reads 1000_0100_0010_0001. busy lasts 67 cycles. serial_load is high for 2 cycles after the 16th bit. done pulses once.
- Issue wr_en (idx 0, 4'hF) and a second start mid-SHIFT -> both ignored. After done, rd_data[0] is still 4'h1 and exactly one done pulse occurs.
- Assert reset in the middle of the 9th bit -> all outputs 0 asynchronously. serial_load never asserts. Image returns to 4'h3. A new start runs a full 67-cycle transfer.
- start and wr_en (idx 3, 4'hA) in the same IDLE cycle -> the first 4 shifted bits are 1010.
- With PAD_CFG_READBACK_EN, loop the chain with a 16-bit model:
  - First transfer -> rb_mismatch=0.
  - Corrupt one model bit, then transfer again -> rb_mismatch=1 at done.
  - Next start -> rb_mismatch clears.
